// File: rtl/apb_mem_pkg.sv
// Shared types and constants for the APB memory completer.
// The APB_SLV_PSTRB_EN macro enables byte-strobe writes in the interface and top level.
package apb_mem_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      READY
   } state_e;

   localparam int unsigned CNT_W = 4;

   function automatic int unsigned strb_w(input int unsigned data_w);
      return data_w / 8;
   endfunction

endpackage

// File: rtl/apb_mem_if.sv
// APB bus bundle between the bridge decoder (master) and one memory completer (slave).
// PSTRB exists only when APB_SLV_PSTRB_EN is defined.
interface apb_mem_if
   import apb_mem_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 8
) ();

   logic                        PSEL;
   logic                        PENABLE;
   logic                        PWRITE;
   logic [ADDR_W-1:0]           PADDR;
   logic [DATA_W-1:0]           PWDATA;
`ifdef APB_SLV_PSTRB_EN
   logic [strb_w(DATA_W)-1:0]   PSTRB;
`endif
   logic [DATA_W-1:0]           PRDATA;
   logic                        PREADY;
   logic                        PSLVERR;

   modport master (
      output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
`ifdef APB_SLV_PSTRB_EN
             PSTRB,
`endif
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
`ifdef APB_SLV_PSTRB_EN
             PSTRB,
`endif
      output PRDATA, PREADY, PSLVERR
   );

endinterface

// File: rtl/apb_mem_array.sv
// DEPTH x DATA_W register-file storage: asynchronous read, byte-enabled synchronous write.
// Contents are never reset.
module apb_mem_array
   import apb_mem_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 64,
   parameter int unsigned IDX_W  = 6
) (
   input  logic                      clk,
   input  logic                      i_we,
   input  logic [IDX_W-1:0]          i_addr,
   input  logic [strb_w(DATA_W)-1:0] i_be,
   input  logic [DATA_W-1:0]         i_wdata,
   output logic [DATA_W-1:0]         o_rdata
);

   localparam int unsigned STRB_W = strb_w(DATA_W);

   logic [DATA_W-1:0] r_mem [DEPTH];

   assign o_rdata = r_mem[i_addr];

   always_ff @(posedge clk) begin
      if (i_we) begin
         for (int unsigned b = 0; b < STRB_W; b++) begin
            if (i_be[b]) r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
         end
      end
   end

endmodule

// File: rtl/apb_mem_slave.sv
// APB completer with register-file storage, WAIT_STATES wait cycles and out-of-range errors.
// Define APB_SLV_PSTRB_EN for byte-strobe writes and strobe-qualified read errors.
module apb_mem_slave
   import apb_mem_pkg::*;
#(
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned ADDR_W      = 8,
   parameter int unsigned DEPTH       = 64,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic      clk,
   input  logic      reset,
   apb_mem_if.slave  s_apb
);

   localparam int unsigned       STRB_W  = strb_w(DATA_W);
   localparam int unsigned       IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CNT_W-1:0]  WS      = CNT_W'(WAIT_STATES);
   localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);

   state_e             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_pready;
   logic               r_pslverr;
   logic [DATA_W-1:0]  r_prdata;

   logic               w_setup;
   logic               w_in_range;
   logic               w_err;
   logic               w_enter_ready;
   logic               w_we;
   logic [STRB_W-1:0]  w_be;
   logic [IDX_W-1:0]   w_idx;
   logic [DATA_W-1:0]  w_rdata;

   assign w_setup    = s_apb.PSEL && !s_apb.PENABLE;
   assign w_in_range = {1'b0, s_apb.PADDR} < DEPTH_L;
   assign w_idx      = s_apb.PADDR[IDX_W-1:0];

`ifdef APB_SLV_PSTRB_EN
   assign w_be  = s_apb.PSTRB;
   assign w_err = !w_in_range || (!s_apb.PWRITE && (s_apb.PSTRB != '0));
`else
   assign w_be  = '1;
   assign w_err = !w_in_range;
`endif

   // Completion is decided one edge early so PREADY/PSLVERR/PRDATA can all be registered.
   assign w_enter_ready = ((r_state == IDLE) && w_setup && (WS == '0)) ||
                          ((r_state == WAIT) && s_apb.PSEL && (r_cnt == CNT_W'(1)));

   // Error transfers carry PSLVERR through READY, which also blocks the write.
   assign w_we = reset && (r_state == READY) && s_apb.PSEL && s_apb.PENABLE &&
                 s_apb.PWRITE && !r_pslverr;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_pready  <= 1'b0;
         r_pslverr <= 1'b0;
         r_prdata  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_setup) begin
                  r_cnt   <= WS;
                  r_state <= (WS == '0) ? READY : WAIT;
               end
            end
            WAIT: begin
               if (!s_apb.PSEL) begin
                  r_cnt   <= '0;
                  r_state <= IDLE;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
                  if (r_cnt == CNT_W'(1)) r_state <= READY;
               end
            end
            READY:   r_state <= IDLE;
            default: r_state <= IDLE;
         endcase

         r_pready  <= w_enter_ready;
         r_pslverr <= w_enter_ready && w_err;
         if (w_enter_ready) begin
            if (w_err)              r_prdata <= '0;
            else if (!s_apb.PWRITE) r_prdata <= w_rdata;
         end
      end
   end

   apb_mem_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W)
   ) u_array (
      .clk     (clk),
      .i_we    (w_we),
      .i_addr  (w_idx),
      .i_be    (w_be),
      .i_wdata (s_apb.PWDATA),
      .o_rdata (w_rdata)
   );

   assign s_apb.PREADY  = r_pready;
   assign s_apb.PSLVERR = r_pslverr;
   assign s_apb.PRDATA  = r_prdata;

endmodule

// File: tb/tb_apb_mem_slave.sv
// Bench for apb_mem_slave: three instances (WAIT_STATES 0, 2, 3) share one APB master and
// are checked against a word-array reference model. Honours APB_SLV_PSTRB_EN.
module tb_apb_mem_slave;

   localparam int unsigned DW    = 32;
   localparam int unsigned AW    = 8;
   localparam int unsigned DEPTH = 64;
   localparam int unsigned NDUT  = 3;
   localparam int unsigned SW    = DW / 8;

   function automatic int unsigned ws_of(input int unsigned g);
      return (g == 0) ? 0 : ((g == 1) ? 2 : 3);
   endfunction

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic          psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
   logic [AW-1:0] paddr  = '0;
   logic [DW-1:0] pwdata = '0;
   logic [SW-1:0] pstrb  = '0;

   logic          rdy   [NDUT];
   logic          err   [NDUT];
   logic [DW-1:0] rdata [NDUT];

   always #5 clk = ~clk;

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      apb_mem_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
      assign bus.PSEL    = psel;
      assign bus.PENABLE = penable;
      assign bus.PWRITE  = pwrite;
      assign bus.PADDR   = paddr;
      assign bus.PWDATA  = pwdata;
`ifdef APB_SLV_PSTRB_EN
      assign bus.PSTRB   = pstrb;
`endif
      assign rdy[g]   = bus.PREADY;
      assign err[g]   = bus.PSLVERR;
      assign rdata[g] = bus.PRDATA;

      apb_mem_slave #(
         .DATA_W      (DW),
         .ADDR_W      (AW),
         .DEPTH       (DEPTH),
         .WAIT_STATES (ws_of(g))
      ) u_dut (
         .clk   (clk),
         .reset (rst_n),
         .s_apb (bus)
      );
   end

   int checks   = 0;
   int failures = 0;

   // Reference model: memory words plus the PRDATA value a completer is holding.
   logic [DW-1:0] mem_m [DEPTH];
   logic [DW-1:0] prdata_m = '0;

   int            obs_lat    [NDUT];
   int            obs_pulses [NDUT];
   logic [DW-1:0] obs_data   [NDUT];
   logic          obs_err    [NDUT];

   task automatic model(input bit wr, input int addr, input logic [DW-1:0] wd,
                        input logic [SW-1:0] st, output bit e_err);
      logic [SW-1:0] lanes;
      bit            strobe_err;
      strobe_err = 1'b0;
      lanes      = '1;
`ifdef APB_SLV_PSTRB_EN
      lanes      = st;
      strobe_err = !wr && (st != '0);
`endif
      e_err = (addr >= int'(DEPTH)) || strobe_err;
      if (e_err) prdata_m = '0;
      else if (wr) begin
         for (int b = 0; b < int'(SW); b++)
            if (lanes[b]) mem_m[addr][b*8 +: 8] = wd[b*8 +: 8];
      end else prdata_m = mem_m[addr];
   endtask

   // Runs one transfer from posedge+1; returns at posedge+1 with the bus idle.
   task automatic drive(input bit wr, input int addr, input logic [DW-1:0] wd,
                        input logic [SW-1:0] st);
      bit all_done;
      for (int g = 0; g < int'(NDUT); g++) begin
         obs_lat[g] = -1; obs_pulses[g] = 0; obs_data[g] = 'x; obs_err[g] = 1'bx;
      end
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = AW'(addr); pwdata = wd; pstrb = st;
      for (int k = 0; k <= 20; k++) begin
         @(negedge clk);
         all_done = 1'b1;
         for (int g = 0; g < int'(NDUT); g++) begin
            if (rdy[g] === 1'b1) begin
               obs_pulses[g]++;
               if (obs_lat[g] < 0) begin
                  obs_lat[g] = k; obs_data[g] = rdata[g]; obs_err[g] = err[g];
               end
            end
            if (obs_lat[g] < 0) all_done = 1'b0;
         end
         @(posedge clk); #1;
         penable = 1'b1;
         if (all_done && k > 0) break;
      end
      psel = 1'b0; penable = 1'b0;
   endtask

   task automatic xfer(input bit wr, input int addr, input logic [DW-1:0] wd,
                       input logic [SW-1:0] st, output bit e_err);
      drive(wr, addr, wd, st);
      model(wr, addr, wd, st, e_err);
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int g = 0; g < int'(NDUT); g++) begin
         checks++;
         if (rdy[g] !== 1'b0 || err[g] !== 1'b0 || rdata[g] !== '0) begin
            failures++;
            $display("FAIL reset dut%0d: PREADY=%b PSLVERR=%b PRDATA=%h, expected 0 0 0",
                     g, rdy[g], err[g], rdata[g]);
         end
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      prdata_m = '0;
   endtask

   task automatic test_fill();
      bit e;
      for (int a = 0; a < int'(DEPTH); a++) begin
         xfer(1'b1, a, $urandom, '1, e);
         for (int g = 0; g < int'(NDUT); g++) begin
            checks++;
            if (obs_lat[g] !== int'(ws_of(g)) + 1 || obs_err[g] !== 1'b0) begin
               failures++;
               $display("FAIL fill dut%0d addr %0d: latency=%0d PSLVERR=%b, expected %0d 0",
                        g, a, obs_lat[g], obs_err[g], ws_of(g) + 1);
            end
         end
      end
   endtask

   task automatic test_basic();
      bit e;
      xfer(1'b1, 5, 32'hDEADBEEF, '1, e);
      xfer(1'b0, 5, '0, '0, e);
      for (int g = 0; g < int'(NDUT); g++) begin
         checks++;
         if (obs_lat[g] !== int'(ws_of(g)) + 1 || obs_pulses[g] !== 1) begin
            failures++;
            $display("FAIL basic_timing dut%0d: latency=%0d pulses=%0d, expected %0d 1",
                     g, obs_lat[g], obs_pulses[g], ws_of(g) + 1);
         end
         checks++;
         if (obs_data[g] !== 32'hDEADBEEF || obs_err[g] !== 1'b0) begin
            failures++;
            $display("FAIL basic_read dut%0d: PRDATA=%h PSLVERR=%b, expected deadbeef 0",
                     g, obs_data[g], obs_err[g]);
         end
      end
   endtask

   task automatic test_oob();
      bit e;
      logic [DW-1:0] before63;
      before63 = mem_m[63];
      for (int step = 0; step < 3; step++) begin
         case (step)
            0:       xfer(1'b1, 64, $urandom, '1, e);
            1:       xfer(1'b0, 64, '0, '0, e);
            default: xfer(1'b0, 63, '0, '0, e);
         endcase
         for (int g = 0; g < int'(NDUT); g++) begin
            checks++;
            if (obs_err[g] !== (step < 2) || obs_lat[g] !== int'(ws_of(g)) + 1) begin
               failures++;
               $display("FAIL oob_err step%0d dut%0d: PSLVERR=%b latency=%0d, expected %b %0d",
                        step, g, obs_err[g], obs_lat[g], step < 2, ws_of(g) + 1);
            end
            checks++;
            if (obs_data[g] !== ((step < 2) ? '0 : before63)) begin
               failures++;
               $display("FAIL oob_data step%0d dut%0d: PRDATA=%h, expected %h",
                        step, g, obs_data[g], (step < 2) ? '0 : before63);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      bit e;
      logic [DW-1:0] v;
      v = $urandom;
      xfer(1'b1, 1, v, '1, e);
      xfer(1'b0, 1, '0, '0, e);
      for (int g = 0; g < int'(NDUT); g++) begin
         checks++;
         if (obs_lat[g] !== int'(ws_of(g)) + 1 || obs_data[g] !== v || obs_err[g] !== 1'b0) begin
            failures++;
            $display("FAIL b2b dut%0d: latency=%0d PRDATA=%h PSLVERR=%b, expected %0d %h 0",
                     g, obs_lat[g], obs_data[g], obs_err[g], ws_of(g) + 1, v);
         end
      end
   endtask

   task automatic test_random();
      bit e;
      bit wr;
      int addr;
      logic [SW-1:0] st;
      for (int n = 0; n < 40; n++) begin
         wr   = 1'($urandom);
         addr = $urandom_range(0, DEPTH + 7);
         st   = wr ? SW'($urandom) : (($urandom_range(0, 3) == 0) ? SW'($urandom) : '0);
         xfer(wr, addr, $urandom, st, e);
         for (int g = 0; g < int'(NDUT); g++) begin
            checks++;
            if (obs_lat[g] !== int'(ws_of(g)) + 1 || obs_pulses[g] !== 1 ||
                obs_err[g] !== e || obs_data[g] !== prdata_m) begin
               failures++;
               $display("FAIL random#%0d dut%0d wr=%b addr=%0d: lat=%0d pulses=%0d err=%b data=%h, expected lat=%0d pulses=1 err=%b data=%h",
                        n, g, wr, addr, obs_lat[g], obs_pulses[g], obs_err[g], obs_data[g],
                        ws_of(g) + 1, e, prdata_m);
            end
         end
         idle($urandom_range(0, 2));
      end
   endtask

`ifdef APB_SLV_PSTRB_EN
   task automatic test_strobe();
      bit e;
      logic [DW-1:0] expv [4];
      xfer(1'b1, 7, 32'h11223344, '1, e);
      xfer(1'b1, 7, 32'hAABBCCDD, 4'b0101, e);
      xfer(1'b0, 7, '0, '0, e);
      expv[0] = 32'h11BB33DD;
      for (int g = 0; g < int'(NDUT); g++) begin
         checks++;
         if (obs_data[g] !== expv[0] || obs_err[g] !== 1'b0) begin
            failures++;
            $display("FAIL strobe_write dut%0d: PRDATA=%h PSLVERR=%b, expected %h 0",
                     g, obs_data[g], obs_err[g], expv[0]);
         end
      end
      xfer(1'b1, 7, $urandom, 4'b0000, e);
      xfer(1'b0, 7, '0, '0, e);
      for (int g = 0; g < int'(NDUT); g++) begin
         checks++;
         if (obs_data[g] !== expv[0] || obs_err[g] !== 1'b0) begin
            failures++;
            $display("FAIL strobe_zero dut%0d: PRDATA=%h PSLVERR=%b, expected %h 0",
                     g, obs_data[g], obs_err[g], expv[0]);
         end
      end
      xfer(1'b0, 7, '0, 4'b0001, e);
      for (int g = 0; g < int'(NDUT); g++) begin
         checks++;
         if (obs_err[g] !== 1'b1 || obs_data[g] !== '0 || obs_lat[g] !== int'(ws_of(g)) + 1) begin
            failures++;
            $display("FAIL strobe_read_err dut%0d: PSLVERR=%b PRDATA=%h lat=%0d, expected 1 0 %0d",
                     g, obs_err[g], obs_data[g], obs_lat[g], ws_of(g) + 1);
         end
      end
   endtask
`endif

   task automatic test_protocol_violation();
      bit e;
      int pulses [NDUT];
      logic [DW-1:0] old;
      old = mem_m[10];
      for (int g = 0; g < int'(NDUT); g++) pulses[g] = 0;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = AW'(10); pwdata = ~old; pstrb = '1;
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0;
      repeat (6) begin
         @(negedge clk);
         for (int g = 0; g < int'(NDUT); g++) if (rdy[g] === 1'b1) pulses[g]++;
         @(posedge clk); #1;
      end
      for (int g = 0; g < int'(NDUT); g++) begin
         checks++;
         if (pulses[g] !== ((g == 0) ? 1 : 0)) begin
            failures++;
            $display("FAIL abort_pready dut%0d: pulses=%0d, expected %0d",
                     g, pulses[g], (g == 0) ? 1 : 0);
         end
      end
      // The WAIT_STATES=0 instance already returned a completion; its PRDATA stays held.
      xfer(1'b0, 10, '0, '0, e);
      for (int g = 0; g < int'(NDUT); g++) begin
         checks++;
         if (obs_data[g] !== old) begin
            failures++;
            $display("FAIL abort_nowrite dut%0d: PRDATA=%h, expected %h", g, obs_data[g], old);
         end
      end
   endtask

   task automatic test_reset_midwrite();
      bit e;
      int pulses [NDUT];
      logic [DW-1:0] old;
      xfer(1'b0, 5, '0, '0, e);
      old = mem_m[20];
      for (int g = 0; g < int'(NDUT); g++) pulses[g] = 0;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = AW'(20); pwdata = ~old; pstrb = '1;
      @(posedge clk); #1;
      penable = 1'b1;
      rst_n   = 1'b0;
      @(posedge clk); #1;
      rst_n    = 1'b1;
      prdata_m = '0;
      @(negedge clk);
      for (int g = 0; g < int'(NDUT); g++) begin
         checks++;
         if (rdy[g] !== 1'b0 || err[g] !== 1'b0 || rdata[g] !== '0) begin
            failures++;
            $display("FAIL midreset_out dut%0d: PREADY=%b PSLVERR=%b PRDATA=%h, expected 0 0 0",
                     g, rdy[g], err[g], rdata[g]);
         end
      end
      repeat (5) begin
         @(posedge clk); #1;
         @(negedge clk);
         for (int g = 0; g < int'(NDUT); g++) if (rdy[g] === 1'b1) pulses[g]++;
      end
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0;
      for (int g = 0; g < int'(NDUT); g++) begin
         checks++;
         if (pulses[g] !== 0) begin
            failures++;
            $display("FAIL midreset_idle dut%0d: pulses=%0d, expected 0", g, pulses[g]);
         end
      end
      xfer(1'b0, 20, '0, '0, e);
      for (int g = 0; g < int'(NDUT); g++) begin
         checks++;
         if (obs_data[g] !== old || obs_err[g] !== 1'b0) begin
            failures++;
            $display("FAIL midreset_mem dut%0d: PRDATA=%h PSLVERR=%b, expected %h 0",
                     g, obs_data[g], obs_err[g], old);
         end
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_fill();
      test_basic();
      idle(1);
      test_oob();
      test_back_to_back();
      idle(2);
`ifdef APB_SLV_PSTRB_EN
      test_strobe();
      idle(1);
`endif
      test_random();
      idle(1);
      test_protocol_violation();
      idle(1);
      test_reset_midwrite();
      idle(2);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/apb_mem_slave.md
# apb_mem_slave

Parametrised APB completer with register-file storage and a registered, cycle-deterministic response path. It adds configurable wait states, out-of-range error signalling and optional byte-strobe writes. It sits behind the APB bridge decoder, one instance per PSEL line, and replaces the fixed 8-bit, zero-wait peripheral memories.

## Interface
- DATA_W, 32, PWDATA/PRDATA width; multiple of 8
- ADDR_W, 8, PADDR width; PADDR is a word index
- DEPTH, 64, number of DATA_W words; DEPTH ≤ 2^ADDR_W
- WAIT_STATES, 0, wait cycles inserted before PREADY; range 0..15
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low
- PSEL  in  1  select from decoder
- PENABLE  in  1  access phase
- PWRITE  in  1  1 = write, 0 = read
- PADDR  in  ADDR_W  word address
- PWDATA  in  DATA_W  write data
- PSTRB  in  DATA_W/8  byte lane strobes; present only with APB_SLV_PSTRB_EN
- PRDATA  out  DATA_W  read data; valid while PREADY=1
- PREADY  out  1  transfer completion
- PSLVERR  out  1  error response; qualified by PREADY

## Operation
- FSM states:
  - IDLE: no transfer in progress.
  - WAIT: counting wait cycles.
  - READY: PREADY=1 for exactly one cycle.
- IDLE, on an edge sampling PSEL=1 and PENABLE=0 (setup):
  - Load the wait counter with WAIT_STATES.
  - Go to READY if WAIT_STATES=0, otherwise to WAIT.
- WAIT:
  - Decrement the counter each edge.
  - Go to READY on the edge where the counter reaches 1.
- READY → IDLE unconditionally.
- Address check: PADDR ≥ DEPTH is an error transfer.
  - PSLVERR=1 and PRDATA=0 in READY.
  - A write is suppressed.
- Read: PRDATA is loaded from mem[PADDR] on the edge entering READY. PRDATA is held after READY until the next read completes.
- Write: mem[PADDR] is updated on the READY-cycle edge only when PSEL=PENABLE=PWRITE=1 is sampled there.
- PSEL sampled 0 in WAIT or READY (protocol violation): return to IDLE, no write, PREADY=0.
- PSLVERR is 0 whenever PREADY=0.
- Memory contents are not cleared by reset and are undefined after power-up.

## Timing
- All outputs are registered. Reset value: PREADY=0, PSLVERR=0, PRDATA=0, state IDLE, counter 0.
- Latency: PREADY asserts in access cycle WAIT_STATES+1. The transfer spans WAIT_STATES+2 cycles including setup.
- Back-to-back transfers: a setup phase in the cycle after READY is accepted from IDLE with no dead cycle.
- Reset low on any edge, including mid-transfer: outputs and FSM return to reset values at that edge, and the in-flight write is discarded.
- Read after write to the same address: the next transfer returns the new data.

## Configuration
- APB_SLV_PSTRB_EN defined:
  - The PSTRB port exists.
  - A write updates only the byte lanes with PSTRB[i]=1.
  - PSTRB=0 on a write is a legal no-op completion.
  - A read with PSTRB≠0 completes with PSLVERR=1.
- APB_SLV_PSTRB_EN undefined:
  - The PSTRB port is absent.
  - Writes update the full word.
  - Reads never error on strobes.

## Structure
- Package apb_mem_pkg holds:
  - The FSM state enum (IDLE, WAIT, READY).
  - The STRB_W = DATA_W/8 constant function.
  - The wait-counter width constant (4 bits).
- Sub-module apb_mem_array: DEPTH×DATA_W storage with an asynchronous read port and a byte-enable synchronous write port. The top level drives its byte enables as all-ones when strobes are compiled out.

## Test plan
- WAIT_STATES=0: write 0xDEADBEEF to addr 5, then read addr 5 → PREADY in the first access cycle both times, PRDATA=0xDEADBEEF, PSLVERR=0.
- WAIT_STATES=2: read addr 3 → PREADY low for 2 access cycles, high on the 3rd for exactly one cycle.
- DEPTH=64: write to addr 64, then read addr 64 → PSLVERR=1 with PREADY on both, PRDATA=0; reading addr 63 afterwards shows its prior value unchanged.
- APB_SLV_PSTRB_EN: preload addr 7 with 0x11223344, write 0xAABBCCDD with PSTRB=0b0101 → read returns 0x11BB33DD. A read with PSTRB=0b0001 → PSLVERR=1.
- Reset low during the WAIT cycle of a write with WAIT_STATES=3 → PREADY=0 next cycle, FSM IDLE, target word unchanged on readback.
- Back-to-back write addr 1 then read addr 1 with no idle cycle → both complete, read returns the written data.
